// File: rtl/des_sbox_seq.sv
// des_sbox_seq -- time-multiplexed DES S-box substitution unit.
//
// Takes the 48-bit keyed half-block (E(R) xor K) and produces the 32-bit
// S-box result. SBOX_PER_CYCLE of the eight S-boxes are evaluated per clock,
// so a result takes 8/SBOX_PER_CYCLE cycles.
//
// Optional feature macro: DES_SBOX_PERM_EN
//   defined     -> out_data is the DES P permutation of S1..S8
//   not defined -> out_data is the raw concatenation S1..S8
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data valid
//   in_ready   unit accepts in_data this cycle (combinational from out_ready)
//   in_data    [1:48] DES bit order, bits 6k-5..6k feed S-box k
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data this cycle
//   out_data   [1:32] result
//   busy       high while the substitution is in progress
module des_sbox_seq #(
  parameter int SBOX_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] out_data,
  output logic        busy
);

  localparam int unsigned N     = SBOX_PER_CYCLE;
  localparam int unsigned STEPS = (N == 0) ? 1 : 8 / N;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  generate
    if (!(N == 1 || N == 2 || N == 4 || N == 8)) begin : g_bad_param
      $error("des_sbox_seq: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  // One 64-entry table per box, entry (row*16 + col) at bits 255-4i..252-4i.
  localparam logic [255:0] STAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAB17E608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lu(input logic [2:0] box, input logic [5:0] grp);
    logic [5:0]   idx;
    logic [255:0] row;
    idx = {grp[5], grp[0], grp[4:1]};
    row = STAB[box] >> (8'd252 - {idx, 2'b00});
    return row[3:0];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] step;
  logic [47:0]   din;
  logic [31:0]   res;
  logic [31:0]   res_next;
  logic [2:0]    box;
  logic [5:0]    grp;
  logic [4:0]    sh;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);

  // Only the N boxes selected by the step counter are looked up; the other
  // nibbles of the result register keep their value.
  always_comb begin
    res_next = res;
    box      = '0;
    grp      = '0;
    sh       = '0;
    for (int unsigned j = 0; j < N; j++) begin
      box      = 3'(32'(step) * N + j);
      grp      = 6'(din >> (42 - 6 * 32'(box)));
      sh       = 5'(28 - 4 * 32'(box));
      res_next = (res_next & ~(32'hF << sh)) | (32'(sbox_lu(box, grp)) << sh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      din       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            din   <= in_data;
            step  <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          res <= res_next;
          if (step == LAST) begin
            step      <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              din   <= in_data;
              step  <= '0;
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          step      <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DES_SBOX_PERM_EN
  localparam int unsigned PTAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  logic [31:0] perm;

  // Output bit i+1 (1 = MSB) takes raw bit PTAB[i] of the result register.
  always_comb begin
    perm = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      perm = perm | (((res >> (32 - PTAB[i])) & 32'd1) << (31 - i));
    end
  end
  assign out_data = perm;
`else
  assign out_data = res;
`endif

endmodule

// File: tb/tb_des_sbox_seq.sv
// Self-checking bench for des_sbox_seq: four instances (1, 2, 4, 8 boxes per
// cycle) against a table-driven reference model of the DES S-box function.
module tb_des_sbox_seq;

  logic        clk;
  logic        rst;
  logic        iv    [4];
  logic        ir    [4];
  logic [1:48] idata [4];
  logic        ov    [4];
  logic        ordy  [4];
  logic [1:32] odata [4];
  logic        bz    [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_seq #(.SBOX_PER_CYCLE(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (idata[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (odata[g]),
      .busy      (bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int sbt [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  int ptab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] model(input logic [47:0] x);
    logic [31:0] raw;
    logic [31:0] p;
    int b, row, col;
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      b   = int'((x >> (42 - 6 * k)) & 48'h3F);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      raw = (raw << 4) | 32'(sbt[k][row][col]);
    end
    p = raw;
`ifdef DES_SBOX_PERM_EN
    p = '0;
    for (int i = 0; i < 32; i++) p = (p << 1) | ((raw >> (32 - ptab[i])) & 32'd1);
`endif
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one vector, wait for the result, check latency/busy/data, consume it.
  task automatic run_vec(input int g, input logic [47:0] v, input logic [31:0] exp,
                         input int lat_exp, input string tag);
    int k, bc;
    chk({tag, "_in_ready"}, 64'(ir[g]), 64'd1);
    iv[g] = 1'b1;
    idata[g] = v;
    tick;
    iv[g] = 1'b0;
    idata[g] = ~v;
    k = 0;
    bc = 0;
    while (!ov[g] && k < 40) begin
      bc += int'(bz[g]);
      tick;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat_exp));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(lat_exp));
    chk({tag, "_data"}, 64'(odata[g]), 64'(exp));
    chk({tag, "_ready_in_done"}, 64'(ir[g]), 64'd0);
    ordy[g] = 1'b1;
    tick;
    ordy[g] = 1'b0;
    chk({tag, "_valid_drop"}, 64'(ov[g]), 64'd0);
  endtask

  logic [47:0] kv, v1, v2, rv;
  logic [31:0] kv_exp, c0_exp, c1_exp, hold_exp;
  int k, t1, t2, seen;

  initial begin
    kv = 48'h6117BA866527;
`ifdef DES_SBOX_PERM_EN
    kv_exp = 32'h234AA9BB;
    c0_exp = model(48'h0);
    c1_exp = model(48'hFFFFFFFFFFFF);
`else
    kv_exp = 32'h5C82B597;
    c0_exp = 32'hEFA72C4D;
    c1_exp = 32'hD9CE3DCB;
`endif
    for (int g = 0; g < 4; g++) begin
      iv[g] = 1'b0;
      idata[g] = '0;
      ordy[g] = 1'b0;
    end
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 64'(ir[1]), 64'd1);
    chk("rst_out_valid", 64'(ov[1]), 64'd0);
    chk("rst_busy", 64'(bz[1]), 64'd0);
    chk("rst_out_data", 64'(odata[1]), 64'd0);

    // Known vector and table corners at N=2.
    run_vec(1, kv, kv_exp, 4, "kv_n2");
    run_vec(1, 48'h0, c0_exp, 4, "zeros");
    run_vec(1, 48'hFFFFFFFFFFFF, c1_exp, 4, "ones");

    // Latency sweep across all widths.
    run_vec(0, kv, kv_exp, 8, "kv_n1");
    run_vec(2, kv, kv_exp, 2, "kv_n4");
    run_vec(3, kv, kv_exp, 1, "kv_n8");

    // Random vectors against the model on every width.
    for (int i = 0; i < 12; i++) begin
      rv = {16'($urandom), 32'($urandom)};
      run_vec(i % 4, rv, model(rv), 8 >> (i % 4), "rand");
    end

    // Backpressure: hold DONE for 10 cycles while in_valid pulses.
    v1 = {16'($urandom), 32'($urandom)};
    hold_exp = model(v1);
    iv[1] = 1'b1;
    idata[1] = v1;
    tick;
    iv[1] = 1'b0;
    k = 0;
    while (!ov[1] && k < 40) begin
      tick;
      k++;
    end
    chk("bp_latency", 64'(k), 64'd4);
    for (int i = 0; i < 10; i++) begin
      iv[1] = i[0];
      idata[1] = {16'($urandom), 32'($urandom)};
      chk("bp_in_ready", 64'(ir[1]), 64'd0);
      tick;
      chk("bp_out_valid", 64'(ov[1]), 64'd1);
      chk("bp_out_data", 64'(odata[1]), 64'(hold_exp));
      chk("bp_busy", 64'(bz[1]), 64'd0);
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
    chk("bp_release", 64'(ov[1]), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen += int'(ov[1]);
    end
    chk("bp_single_transfer", 64'(seen), 64'd0);

    // Back-to-back with in_valid and out_ready held high.
    v1 = {16'($urandom), 32'($urandom)};
    v2 = v1 ^ 48'h5A5A5A5A5A5A;
    iv[1] = 1'b1;
    idata[1] = v1;
    ordy[1] = 1'b1;
    tick;
    idata[1] = v2;
    k = 0;
    while (!ov[1] && k < 40) begin
      tick;
      k++;
    end
    t1 = cyc;
    chk("b2b_first_latency", 64'(k), 64'd4);
    chk("b2b_first_data", 64'(odata[1]), 64'(model(v1)));
    chk("b2b_in_ready", 64'(ir[1]), 64'd1);
    tick;
    iv[1] = 1'b0;
    chk("b2b_second_busy", 64'(bz[1]), 64'd1);
    chk("b2b_valid_gap", 64'(ov[1]), 64'd0);
    k = 0;
    while (!ov[1] && k < 40) begin
      tick;
      k++;
    end
    t2 = cyc;
    chk("b2b_spacing", 64'(t2 - t1), 64'd5);
    chk("b2b_second_data", 64'(odata[1]), 64'(model(v2)));
    tick;
    ordy[1] = 1'b0;
    chk("b2b_drain", 64'(ov[1]), 64'd0);

    // Reset mid-RUN discards the operation.
    iv[1] = 1'b1;
    idata[1] = kv;
    tick;
    iv[1] = 1'b0;
    tick;
    chk("mid_busy", 64'(bz[1]), 64'd1);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(ir[1]), 64'd1);
    chk("mid_rst_out_valid", 64'(ov[1]), 64'd0);
    chk("mid_rst_busy", 64'(bz[1]), 64'd0);
    chk("mid_rst_out_data", 64'(odata[1]), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen += int'(ov[1]);
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
